icache_fill_engine: RTL and testbench

ICACHE_FILL_ENGINE -- requirements
Module: icache_fill_engine

---
 rtl/icache_fill_engine.sv | 131 +++++++++++++
 tb/tb_icache_fill_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_engine.sv
// Instruction-cache block fill engine: fetches a B-byte block one word at a time on a miss,
// then streams it as 64-bit replacement beats. Define ICACHE_FILL_PERF_CNT_EN for fill_count_o.
module icache_fill_engine #(
    parameter int unsigned B = 64
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        instr_miss_f_i,
    input  logic [31:0] pc_f_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rep_ready_o,
    output logic [63:0] rep_word_o,
    output logic [31:0] fill_count_o
);

    localparam int unsigned Words = B / 4;
    localparam int unsigned Beats = B / 8;
    localparam int unsigned BLog  = $clog2(B);
    localparam int unsigned IdxW  = $clog2(Words);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StStream, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            abort_q, abort_d;
    logic [31:0]     buffer_q [Words];
    logic            buf_we;
    logic            last_beat;
    logic [IdxW-1:0] lo_idx, hi_idx;
    logic [BLog-1:0] unused_pc_lsbs;

    assign unused_pc_lsbs = pc_f_i[BLog-1:0];
    assign last_beat      = (state_q == StStream) && (idx_q == IdxW'(Beats - 1));

    // idx_q doubles as the beat counter in StStream: it wraps to 0 after the last word.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        abort_d     = abort_q;
        buf_we      = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = 32'd0;
        rep_ready_o = 1'b0;
        rep_word_o  = 64'd0;
        lo_idx      = idx_q << 1;
        hi_idx      = lo_idx | IdxW'(1);

        unique case (state_q)
            StIdle: begin
                if (instr_miss_f_i) begin
                    base_d  = {pc_f_i[31:BLog], {BLog{1'b0}}};
                    idx_d   = '0;
                    abort_d = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_q + {{(30 - IdxW){1'b0}}, idx_q, 2'b00};
                if (!instr_miss_f_i) abort_d = 1'b1;
                if (mem_gnt_i) state_d = StWait;
            end
            StWait: begin
                if (!instr_miss_f_i) abort_d = 1'b1;
                if (mem_rvalid_i) begin
                    // Data returned alongside (or after) an abort is dropped.
                    if (abort_d) begin
                        state_d = StDrain;
                    end else begin
                        buf_we  = 1'b1;
                        idx_d   = idx_q + IdxW'(1);
                        state_d = (idx_q == IdxW'(Words - 1)) ? StStream : StReq;
                    end
                end
            end
            StStream: begin
                rep_ready_o = 1'b1;
                rep_word_o  = {buffer_q[hi_idx], buffer_q[lo_idx]};
                idx_d       = idx_q + IdxW'(1);
                if (last_beat) state_d = StDrain;
            end
            StDrain: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            base_q  <= 32'd0;
            idx_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            abort_q <= abort_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_we) buffer_q[idx_q] <= mem_rdata_i;
    end

`ifdef ICACHE_FILL_PERF_CNT_EN
    logic [31:0] fill_count_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            fill_count_q <= 32'd0;
        end else if (last_beat) begin
            fill_count_q <= fill_count_q + 32'd1;
        end
    end

    assign fill_count_o = fill_count_q;
`else
    assign fill_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_icache_fill_engine.sv
// Directed bench for icache_fill_engine (B=64) with a latency-configurable memory responder.
module tb_icache_fill_engine;

`ifdef ICACHE_FILL_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        miss;
    logic [31:0] pc;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        rep_ready;
    logic [63:0] rep_word;
    logic [31:0] fill_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder / monitor state (written only by the negedge process).
    logic [31:0] addr_log [256];
    logic [63:0] beats [256];
    int          beat_cyc [256];
    int          naddr = 0, nbeats = 0, cyc = 0;
    int          addr_instab = 0, nonzero_idle = 0;
    bit          pending = 1'b0, req_seen = 1'b0;
    logic [31:0] paddr = 32'd0, held = 32'd0;
    int          gcnt = 0, rv_cnt = 0;

    // Controls written only by the main sequence.
    bit rand_mode = 1'b0, stray_rv = 1'b0;
    int gnt_delay = 0, rv_delay = 0;

    always #5 clk = ~clk;

    icache_fill_engine #(.B(64)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .instr_miss_f_i(miss),
        .pc_f_i        (pc),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (gnt),
        .mem_rvalid_i  (rvalid),
        .mem_rdata_i   (rdata),
        .rep_ready_o   (rep_ready),
        .rep_word_o    (rep_word),
        .fill_count_o  (fill_count)
    );

    // Memory model: data = address; drives on negedge so the DUT sees it at the next posedge.
    always @(negedge clk) begin
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'd0;
        cyc++;
        if (!reset_ni) begin
            pending  = 1'b0;
            req_seen = 1'b0;
        end else if (pending) begin
            if (rv_cnt == 0) begin
                rvalid  = 1'b1;
                rdata   = paddr;
                pending = 1'b0;
            end else begin
                rv_cnt--;
            end
        end else if (mem_req) begin
            if (req_seen) begin
                if (mem_addr !== held) addr_instab++;
            end else begin
                held     = mem_addr;
                req_seen = 1'b1;
                gcnt     = rand_mode ? int'($urandom_range(0, 5)) : gnt_delay;
            end
            if (gcnt == 0) begin
                gnt      = 1'b1;
                pending  = 1'b1;
                paddr    = mem_addr;
                req_seen = 1'b0;
                rv_cnt   = rand_mode ? int'($urandom_range(0, 5)) : rv_delay;
                if (naddr < 256) addr_log[naddr] = mem_addr;
                naddr++;
            end else begin
                gcnt--;
            end
        end
        if (stray_rv) begin
            rvalid = 1'b1;
            rdata  = 32'hdead_beef;
        end
        if (rep_ready) begin
            if (nbeats < 256) begin
                beats[nbeats]    = rep_word;
                beat_cyc[nbeats] = cyc;
            end
            nbeats++;
        end else if (rep_word !== 64'd0) begin
            nonzero_idle++;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] fc_exp(input int n);
        return PerfEn ? 32'(n) : 32'd0;
    endfunction

    task automatic wait_beats(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (nbeats >= n) break;
            step();
        end
        check32("beats_reached", 32'(nbeats), 32'(n));
    endtask

    task automatic check_fill(input logic [31:0] base, input int a0, input int b0);
        for (int i = 0; i < 16; i++)
            check32($sformatf("addr[%0d]", i), addr_log[a0 + i], base + 32'(4 * i));
        for (int k = 0; k < 8; k++)
            check64($sformatf("beat[%0d]", k), beats[b0 + k],
                    {base + 32'(8 * k + 4), base + 32'(8 * k)});
        check32("beat_span", 32'(beat_cyc[b0 + 7] - beat_cyc[b0]), 32'd7);
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req"}, 32'(mem_req), 32'd0);
        check32({tag, "_addr"}, mem_addr, 32'd0);
        check32({tag, "_ready"}, 32'(rep_ready), 32'd0);
        check64({tag, "_word"}, rep_word, 64'd0);
        check32({tag, "_fc"}, fill_count, 32'd0);
    endtask

    initial begin
        int a0, b0;
        reset_ni = 1'b0;
        miss     = 1'b0;
        pc       = 32'd0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset_ni = 1'b1;

        // Zero-latency memory, miss at 0x1234.
        a0 = naddr; b0 = nbeats;
        pc = 32'h0000_1234; miss = 1'b1;
        wait_beats(b0 + 8, 300);
        miss = 1'b0;
        repeat (3) step();
        check_fill(32'h0000_1200, a0, b0);
        check64("beat0_literal", beats[b0], 64'h0000_1204_0000_1200);
        check64("beat7_literal", beats[b0 + 7], 64'h0000_123c_0000_1238);
        check32("t1_nreq", 32'(naddr - a0), 32'd16);
        check32("t1_fc", fill_count, fc_exp(1));
        check32("t1_idle_req", 32'(mem_req), 32'd0);

        // Random stalls, pc changed mid-fill.
        rand_mode = 1'b1;
        a0 = naddr; b0 = nbeats;
        pc = 32'h0000_1234; miss = 1'b1;
        repeat (4) step();
        pc = 32'habcd_0000;
        wait_beats(b0 + 8, 1000);
        miss = 1'b0;
        rand_mode = 1'b0;
        repeat (3) step();
        check_fill(32'h0000_1200, a0, b0);
        check32("t2_nreq", 32'(naddr - a0), 32'd16);
        check32("t2_addr_stable", 32'(addr_instab), 32'd0);
        check32("t2_fc", fill_count, fc_exp(2));

        // Abort during word 5's wait.
        rv_delay = 2;
        a0 = naddr; b0 = nbeats;
        pc = 32'h0000_1234; miss = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (naddr == a0 + 6 && !mem_req) break;
            step();
        end
        check32("t3_in_wait5", 32'(naddr - a0), 32'd6);
        miss = 1'b0;
        repeat (8) step();
        rv_delay = 0;
        check32("t3_no_req6", 32'(naddr - a0), 32'd6);
        check32("t3_no_beats", 32'(nbeats - b0), 32'd0);
        check32("t3_req_low", 32'(mem_req), 32'd0);
        check32("t3_fc", fill_count, fc_exp(2));

        // Miss held through DRAIN: two back-to-back fills.
        a0 = naddr; b0 = nbeats;
        pc = 32'h0000_1234; miss = 1'b1;
        wait_beats(b0 + 16, 600);
        miss = 1'b0;
        repeat (3) step();
        check_fill(32'h0000_1200, a0, b0);
        check_fill(32'h0000_1200, a0 + 16, b0 + 8);
        check32("t4_nreq", 32'(naddr - a0), 32'd32);
        check32("t4_fc", fill_count, fc_exp(4));

        // Reset during STREAM beat 3, then a stray rvalid in IDLE.
        a0 = naddr; b0 = nbeats;
        pc = 32'h0000_1234; miss = 1'b1;
        wait_beats(b0 + 4, 300);
        reset_ni = 1'b0;
        miss = 1'b0;
        step();
        check_reset_outputs("midreset");
        reset_ni = 1'b1;
        stray_rv = 1'b1;
        step();
        stray_rv = 1'b0;
        repeat (3) step();
        check32("t5_no_more_beats", 32'(nbeats - b0), 32'd4);
        check32("t5_req_low", 32'(mem_req), 32'd0);
        check32("t5_nreq", 32'(naddr - a0), 32'd16);

        // Clean fill after the reset at a new block.
        a0 = naddr; b0 = nbeats;
        pc = 32'h0000_0040; miss = 1'b1;
        wait_beats(b0 + 8, 300);
        miss = 1'b0;
        repeat (3) step();
        check_fill(32'h0000_0040, a0, b0);
        check32("t6_fc", fill_count, fc_exp(1));
        check32("idle_word_zero", 32'(nonzero_idle), 32'd0);
        check32("addr_stable_all", 32'(addr_instab), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
